// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for a single register-file write port.
// Each source owns a one-entry holding register; one write is granted per cycle.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit DROP_ZERO  = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       AValid,
  output logic                       AReady,
  input  logic [ADDR_WIDTH-1:0]      AAddr,
  input  logic [DATA_WIDTH-1:0]      AData,
  input  logic                       BValid,
  output logic                       BReady,
  input  logic [ADDR_WIDTH-1:0]      BAddr,
  input  logic [DATA_WIDTH-1:0]      BData,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      WriteAddr,
  output logic [DATA_WIDTH-1:0]      WriteData,
  output logic [(2**ADDR_WIDTH)-1:0] Pending,
  output logic                       Idle
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  a_full_r;
  logic [ADDR_WIDTH-1:0] a_addr_r;
  logic [DATA_WIDTH-1:0] a_data_r;
  logic                  b_full_r;
  logic [ADDR_WIDTH-1:0] b_addr_r;
  logic [DATA_WIDTH-1:0] b_data_r;
  logic                  last_b_r;
  logic                  b_older_r;
  logic                  reg_write_r;
  logic [ADDR_WIDTH-1:0] write_addr_r;
  logic [DATA_WIDTH-1:0] write_data_r;

  logic                  both_full_s;
  logic                  same_addr_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  grant_any_s;
  logic                  a_ready_s;
  logic                  b_ready_s;
  logic                  a_load_s;
  logic                  b_load_s;
  logic                  drop_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic [NUM_REGS-1:0]   pending_s;

  assign both_full_s = a_full_r && b_full_r;
  assign same_addr_s = (a_addr_r == b_addr_r);

  // Grant selection: age settles same-register conflicts, round-robin otherwise.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({a_full_r, b_full_r})
      2'b10: begin
        grant_a_s = 1'b1;
        grant_b_s = 1'b0;
      end
      2'b01: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b1;
      end
      2'b11: begin
        if (same_addr_s) begin
          grant_a_s = !b_older_r;
        end else begin
          grant_a_s = last_b_r;
        end
        grant_b_s = !grant_a_s;
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Granted entry payload.
  always_comb begin
    grant_addr_s = b_addr_r;
    grant_data_s = b_data_r;
    if (grant_a_s) begin
      grant_addr_s = a_addr_r;
      grant_data_s = a_data_r;
    end else begin
      grant_addr_s = b_addr_r;
      grant_data_s = b_data_r;
    end
  end

  assign grant_any_s = grant_a_s || grant_b_s;
  assign drop_s      = DROP_ZERO && (grant_addr_s == {ADDR_WIDTH{1'b0}});
  // Ready depends only on state, so a source may stream through its slot.
  assign a_ready_s   = !a_full_r || grant_a_s;
  assign b_ready_s   = !b_full_r || grant_b_s;
  assign a_load_s    = AValid && a_ready_s;
  assign b_load_s    = BValid && b_ready_s;

  // Holding registers: load on accept, free on grant.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      a_full_r <= 1'b0;
      a_addr_r <= {ADDR_WIDTH{1'b0}};
      a_data_r <= {DATA_WIDTH{1'b0}};
      b_full_r <= 1'b0;
      b_addr_r <= {ADDR_WIDTH{1'b0}};
      b_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (a_load_s) begin
        a_full_r <= 1'b1;
        a_addr_r <= AAddr;
        a_data_r <= AData;
      end else if (grant_a_s) begin
        a_full_r <= 1'b0;
      end
      if (b_load_s) begin
        b_full_r <= 1'b1;
        b_addr_r <= BAddr;
        b_data_r <= BData;
      end else if (grant_b_s) begin
        b_full_r <= 1'b0;
      end
    end
  end

  // Arbitration history: round-robin pointer and relative age of the two entries.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      last_b_r  <= 1'b1;
      b_older_r <= 1'b0;
    end else begin
      if (both_full_s) begin
        last_b_r <= !last_b_r;
      end
      // A fresh A load is younger than whatever B holds, including a same-edge B load.
      if (a_load_s) begin
        b_older_r <= 1'b1;
      end else if (b_load_s) begin
        b_older_r <= 1'b0;
      end
    end
  end

  // Write-port output stage.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      reg_write_r  <= 1'b0;
      write_addr_r <= {ADDR_WIDTH{1'b0}};
      write_data_r <= {DATA_WIDTH{1'b0}};
    end else if (grant_any_s) begin
      reg_write_r <= !drop_s;
      if (!drop_s) begin
        write_addr_r <= grant_addr_s;
        write_data_r <= grant_data_s;
      end
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Pending mask: every register with a write held or on the port.
  always_comb begin
    pending_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_s[r] = ((a_full_r && (a_addr_r == ADDR_WIDTH'(r))) ||
                      (b_full_r && (b_addr_r == ADDR_WIDTH'(r))) ||
                      (reg_write_r && (write_addr_r == ADDR_WIDTH'(r)))) &&
                     !(DROP_ZERO && (r == 0));
    end
  end

  assign AReady    = a_ready_s;
  assign BReady    = b_ready_s;
  assign RegWrite  = reg_write_r;
  assign WriteAddr = write_addr_r;
  assign WriteData = write_data_r;
  assign Pending   = pending_s;
  assign Idle      = !a_full_r && !b_full_r && !reg_write_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a sequence-number based model.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          AValid;
  logic          AReady;
  logic [AW-1:0] AAddr;
  logic [DW-1:0] AData;
  logic          BValid;
  logic          BReady;
  logic [AW-1:0] BAddr;
  logic [DW-1:0] BData;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [NR-1:0] Pending;
  logic          Idle;

  always #5 Clock = ~Clock;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DROP_ZERO(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .Pending(Pending), .Idle(Idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each held write carries a global sequence number (lower = older).
  bit            ma_full, mb_full;
  logic [AW-1:0] ma_addr, mb_addr;
  logic [DW-1:0] ma_data, mb_data;
  int            ma_seq, mb_seq, seq_ctr;
  bit            m_lastb;
  bit            m_rw;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            acc_a, acc_b;
  logic [DW-1:0] golden [NR];
  logic [DW-1:0] m_rf   [NR];
  logic [DW-1:0] dut_rf [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // 0 = nothing to write, 1 = A wins, 2 = B wins
  function automatic int m_winner();
    if (ma_full && mb_full) begin
      if (ma_addr == mb_addr) return (ma_seq < mb_seq) ? 1 : 2;
      return m_lastb ? 1 : 2;
    end
    if (ma_full) return 1;
    if (mb_full) return 2;
    return 0;
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p;
    p = '0;
    if (ma_full) p[ma_addr] = 1'b1;
    if (mb_full) p[mb_addr] = 1'b1;
    if (m_rw)    p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_edge();
    int w;
    bit ra, rb;
    if (m_rw) m_rf[m_waddr] = m_wdata;
    w  = m_winner();
    ra = !ma_full || (w == 1);
    rb = !mb_full || (w == 2);
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (!Reset_n) begin
      ma_full = 1'b0; mb_full = 1'b0;
      m_rw = 1'b0; m_waddr = '0; m_wdata = '0; m_lastb = 1'b1;
      for (int r = 0; r < NR; r++) golden[r] = m_rf[r];
    end else begin
      if (ma_full && mb_full) m_lastb = !m_lastb;
      if (w == 1) begin
        m_rw = (ma_addr != '0);
        if (m_rw) begin m_waddr = ma_addr; m_wdata = ma_data; end
        ma_full = 1'b0;
      end else if (w == 2) begin
        m_rw = (mb_addr != '0);
        if (m_rw) begin m_waddr = mb_addr; m_wdata = mb_data; end
        mb_full = 1'b0;
      end else begin
        m_rw = 1'b0;
      end
      acc_a = AValid && ra;
      acc_b = BValid && rb;
      if (acc_b) begin
        mb_full = 1'b1; mb_addr = BAddr; mb_data = BData; mb_seq = seq_ctr; seq_ctr++;
        if (BAddr != '0) golden[BAddr] = BData;
      end
      if (acc_a) begin
        ma_full = 1'b1; ma_addr = AAddr; ma_data = AData; ma_seq = seq_ctr; seq_ctr++;
        if (AAddr != '0) golden[AAddr] = AData;
      end
    end
  endtask

  task automatic check_model();
    int w;
    w = m_winner();
    chk("AReady", 64'(AReady), 64'(!ma_full || (w == 1)));
    chk("BReady", 64'(BReady), 64'(!mb_full || (w == 2)));
    chk("RegWrite", 64'(RegWrite), 64'(m_rw));
    if (m_rw) begin
      chk("WriteAddr", 64'(WriteAddr), 64'(m_waddr));
      chk("WriteData", 64'(WriteData), 64'(m_wdata));
    end
    chk("Pending", 64'(Pending), 64'(m_pending()));
    chk("Idle", 64'(Idle), 64'(!ma_full && !mb_full && !m_rw));
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check_model();
    if (RegWrite === 1'b1) dut_rf[WriteAddr] = WriteData;
  endtask

  task automatic drive_a(input bit v, input int addr, input int data);
    AValid = v; AAddr = AW'(addr); AData = DW'(data);
  endtask

  task automatic drive_b(input bit v, input int addr, input int data);
    BValid = v; BAddr = AW'(addr); BData = DW'(data);
  endtask

  function automatic logic [63:0] port(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return 64'({rw, a, d});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < NR; r++) begin golden[r] = '0; m_rf[r] = '0; dut_rf[r] = '0; end
    ma_full = 1'b0; mb_full = 1'b0; m_rw = 1'b0; m_waddr = '0; m_wdata = '0;
    m_lastb = 1'b1; seq_ctr = 0; ma_seq = 0; mb_seq = 0;

    // Reset with A requesting: nothing may be accepted.
    Reset_n = 1'b0;
    drive_a(1, 5, 'h77);
    drive_b(0, 0, 0);
    cycle();
    cycle();
    chk("rst_aready", 64'(AReady), 64'd1);
    chk("rst_bready", 64'(BReady), 64'd1);
    chk("rst_port", port(RegWrite, WriteAddr, WriteData), 64'd0);
    chk("rst_pending", 64'(Pending), 64'd0);
    chk("rst_idle", 64'(Idle), 64'd1);
    Reset_n = 1'b1;
    drive_a(0, 0, 0);
    cycle();
    chk("rst_noaccept_idle", 64'(Idle), 64'd1);
    chk("rst_noaccept_pend", 64'(Pending), 64'd0);

    // Single-source stream.
    drive_a(1, 5, 'h11); cycle();
    chk("stream_lat", 64'(RegWrite), 64'd0);
    drive_a(1, 6, 'h22); cycle();
    chk("stream_w0", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd5, 32'h11));
    chk("stream_ready", 64'(AReady), 64'd1);
    drive_a(1, 7, 'h33); cycle();
    chk("stream_w1", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd6, 32'h22));
    drive_a(0, 0, 0); cycle();
    chk("stream_w2", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd7, 32'h33));
    cycle();
    chk("stream_end", 64'(RegWrite), 64'd0);

    // Same-register ordering: B(r9) held while A is granted r10 and then accepts r9.
    drive_a(1, 10, 'h7); drive_b(1, 9, 'h1); cycle();
    chk("order_pend", 64'(Pending), 64'h600);
    chk("order_bready", 64'(BReady), 64'd0);
    drive_a(1, 9, 'h2); drive_b(0, 0, 0); cycle();
    chk("order_w0", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd10, 32'h7));
    chk("order_aready", 64'(AReady), 64'd0);
    drive_a(0, 0, 0); cycle();
    chk("order_w1", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd9, 32'h1));
    cycle();
    chk("order_w2", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd9, 32'h2));
    cycle();
    chk("order_r9", 64'(dut_rf[9]), 64'h2);

    // Contention on different registers: A first.
    drive_a(1, 3, 'hAAAA); drive_b(1, 4, 'hBBBB); cycle();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    chk("cont_pend0", 64'(Pending), 64'h18);
    chk("cont_model_pend0", 64'(m_pending()), 64'h18);
    chk("cont_bready", 64'(BReady), 64'd0);
    cycle();
    chk("cont_w0", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd3, 32'hAAAA));
    chk("cont_pend1", 64'(Pending), 64'h18);
    cycle();
    chk("cont_w1", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd4, 32'hBBBB));
    chk("cont_pend2", 64'(Pending), 64'h10);
    cycle();
    chk("cont_pend3", 64'(Pending), 64'd0);

    // Same register, same edge: B is older.
    drive_a(1, 9, 'h2); drive_b(1, 9, 'h1); cycle();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    chk("tie_aready", 64'(AReady), 64'd0);
    cycle();
    chk("tie_w0", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd9, 32'h1));
    cycle();
    chk("tie_w1", port(RegWrite, WriteAddr, WriteData), port(1'b1, 5'd9, 32'h2));
    cycle();
    chk("tie_r9", 64'(dut_rf[9]), 64'h2);

    // Register zero: consumed silently.
    drive_a(1, 0, 'hDEAD); cycle();
    drive_a(0, 0, 0);
    chk("zero_pend", 64'(Pending), 64'd0);
    chk("zero_busy", 64'(Idle), 64'd0);
    cycle();
    chk("zero_rw", 64'(RegWrite), 64'd0);
    chk("zero_idle", 64'(Idle), 64'd1);

    // Reset while both holding registers are full.
    drive_a(1, 20, 'h55); drive_b(1, 21, 'h66); cycle();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    Reset_n = 1'b0; cycle();
    Reset_n = 1'b1;
    chk("midrst_pend", 64'(Pending), 64'd0);
    chk("midrst_idle", 64'(Idle), 64'd1);
    cycle();
    chk("midrst_rw", 64'(RegWrite), 64'd0);
    cycle();
    chk("midrst_r20", 64'(dut_rf[20]), 64'd0);
    chk("midrst_r21", 64'(dut_rf[21]), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!AValid || acc_a) begin
        if ($urandom_range(0, 9) < 6) drive_a(1, $urandom_range(0, 15), $urandom);
        else AValid = 1'b0;
      end
      if (!BValid || acc_b) begin
        if ($urandom_range(0, 9) < 6) drive_b(1, $urandom_range(0, 15), $urandom);
        else BValid = 1'b0;
      end
      Reset_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    Reset_n = 1'b1;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    for (int k = 0; k < 20 && Idle !== 1'b1; k++) cycle();
    chk("drain_idle", 64'(Idle), 64'd1);
    for (int r = 0; r < NR; r++) chk($sformatf("rf_r%0d", r), 64'(dut_rf[r]), 64'(golden[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
